// File: rtl/qspi_fifo.sv
// Synchronous single-clock FIFO with registered or first-word-fall-through read,
// programmable almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module qspi_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT       = 0,
    parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    input  logic                  flush,
    input  logic                  clear_err,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   CNT_FULL = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   CNT_AF   = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   CNT_AE   = AE_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  ovf_evt;
    logic                  unf_evt;

    assign full         = (count == CNT_FULL);
    assign empty        = (count == '0);
    assign almost_full  = (count >= CNT_AF);
    assign almost_empty = (count <= CNT_AE);

    // flush masks both requests, so nothing it suppresses counts as an error
    assign wr_acc  = wr_en && !full  && !flush;
    assign rd_acc  = rd_en && !empty && !flush;
    assign ovf_evt = wr_en &&  full  && !flush;
    assign unf_evt = rd_en &&  empty && !flush;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (wr_acc && !rd_acc) begin
                count <= count + CNT_ONE;
            end else if (rd_acc && !wr_acc) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // an error in the same cycle as clear_err wins, so no event is lost
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_evt) begin
                overflow <= 1'b1;
            end else if (clear_err) begin
                overflow <= 1'b0;
            end
            if (unf_evt) begin
                underflow <= 1'b1;
            end else if (clear_err) begin
                underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // head word shown combinationally; forced to zero while empty so reset reads 0
            assign data_out = empty ? '0 : mem[rd_ptr];
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] rd_data;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rd_data <= '0;
                end else if (rd_acc) begin
                    rd_data <= mem[rd_ptr];
                end
            end

            assign data_out = rd_data;
        end
    endgenerate

endmodule

// File: tb/tb_qspi_fifo.sv
// Directed bench for qspi_fifo: registered-read instance (u_reg) and FWFT instance (u_fwft),
// both DEPTH=4, AF_LEVEL=3, AE_LEVEL=1.
module tb_qspi_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en0, rd_en0, flush0, clear_err0;
    logic [31:0] data_in0, data_out0;
    logic        full0, empty0, af0, ae0, ovf0, unf0;
    logic [2:0]  count0;
    logic        wr_en1, rd_en1, flush1, clear_err1;
    logic [31:0] data_in1, data_out1;
    logic        full1, empty1, af1, ae1, ovf1, unf1;
    logic [2:0]  count1;

    int checks   = 0;
    int failures = 0;
    logic [31:0] q[$];
    logic [31:0] next_val;
    logic [31:0] exp_val;

    always #5 clk = ~clk;

    qspi_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(2), .FWFT(0), .AF_LEVEL(3), .AE_LEVEL(1)) u_reg (
        .clk(clk), .reset(reset), .wr_en(wr_en0), .data_in(data_in0), .rd_en(rd_en0),
        .flush(flush0), .clear_err(clear_err0), .data_out(data_out0), .full(full0),
        .empty(empty0), .almost_full(af0), .almost_empty(ae0), .count(count0),
        .overflow(ovf0), .underflow(unf0)
    );

    qspi_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(2), .FWFT(1), .AF_LEVEL(3), .AE_LEVEL(1)) u_fwft (
        .clk(clk), .reset(reset), .wr_en(wr_en1), .data_in(data_in1), .rd_en(rd_en1),
        .flush(flush1), .clear_err(clear_err1), .data_out(data_out1), .full(full1),
        .empty(empty1), .almost_full(af1), .almost_empty(ae1), .count(count1),
        .overflow(ovf1), .underflow(unf1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wrap_write();
        wr_en0 = 1'b1;
        data_in0 = next_val;
        q.push_back(next_val);
        next_val = next_val + 32'd1;
        tick();
        wr_en0 = 1'b0;
        chk("wrap_count_le4", {31'd0, (count0 <= 3'd4)}, 32'd1);
    endtask

    task automatic wrap_read();
        rd_en0 = 1'b1;
        tick();
        rd_en0 = 1'b0;
        exp_val = q.pop_front();
        chk("wrap_order", data_out0, exp_val);
    endtask

    initial begin
        reset = 1'b1;
        wr_en0 = 0; rd_en0 = 0; flush0 = 0; clear_err0 = 0; data_in0 = 0;
        wr_en1 = 0; rd_en1 = 0; flush1 = 0; clear_err1 = 0; data_in1 = 0;
        next_val = 32'h100;
        #2;
        chk("rst_count", {29'd0, count0}, 32'd0);
        chk("rst_empty", {31'd0, empty0}, 32'd1);
        chk("rst_full", {31'd0, full0}, 32'd0);
        chk("rst_ae", {31'd0, ae0}, 32'd1);
        chk("rst_af", {31'd0, af0}, 32'd0);
        chk("rst_ovf", {31'd0, ovf0}, 32'd0);
        chk("rst_unf", {31'd0, unf0}, 32'd0);
        chk("rst_dout", data_out0, 32'd0);
        chk("rst_fwft_dout", data_out1, 32'd0);
        tick();
        reset = 1'b0;

        // fill
        for (int i = 0; i < 4; i++) begin
            wr_en0 = 1'b1;
            data_in0 = 32'hA0 + i;
            tick();
            chk("fill_count", {29'd0, count0}, i + 1);
            chk("fill_af", {31'd0, af0}, (i + 1 >= 3) ? 32'd1 : 32'd0);
            chk("fill_full", {31'd0, full0}, (i + 1 == 4) ? 32'd1 : 32'd0);
            chk("fill_ae", {31'd0, ae0}, (i + 1 <= 1) ? 32'd1 : 32'd0);
            chk("fill_empty", {31'd0, empty0}, 32'd0);
        end
        data_in0 = 32'hA4;
        tick();
        wr_en0 = 1'b0;
        chk("ovf_flag", {31'd0, ovf0}, 32'd1);
        chk("ovf_count", {29'd0, count0}, 32'd4);

        // drain
        for (int i = 0; i < 4; i++) begin
            rd_en0 = 1'b1;
            tick();
            chk("drain_dout", data_out0, 32'hA0 + i);
            chk("drain_count", {29'd0, count0}, 3 - i);
        end
        chk("drain_empty", {31'd0, empty0}, 32'd1);
        tick();
        rd_en0 = 1'b0;
        chk("unf_flag", {31'd0, unf0}, 32'd1);
        chk("unf_hold", data_out0, 32'hA3);

        // clear_err loses to a simultaneous underflow, then clears on its own
        rd_en0 = 1'b1; clear_err0 = 1'b1;
        tick();
        rd_en0 = 1'b0;
        chk("clr_vs_unf_unf", {31'd0, unf0}, 32'd1);
        chk("clr_vs_unf_ovf", {31'd0, ovf0}, 32'd0);
        tick();
        clear_err0 = 1'b0;
        chk("clr_unf", {31'd0, unf0}, 32'd0);

        // wrap
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 3; i++) wrap_write();
            for (int i = 0; i < 2; i++) wrap_read();
            for (int i = 0; i < 3; i++) wrap_write();
            for (int i = 0; i < 4; i++) wrap_read();
        end
        chk("wrap_empty", {31'd0, empty0}, 32'd1);

        // simultaneous read/write
        wr_en0 = 1'b1;
        data_in0 = 32'hB0; tick();
        data_in0 = 32'hB1; tick();
        rd_en0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_in0 = 32'hB2 + i;
            tick();
            chk("simul_dout", data_out0, 32'hB0 + i);
            chk("simul_count", {29'd0, count0}, 32'd2);
        end
        rd_en0 = 1'b0;
        data_in0 = 32'hB7; tick();
        data_in0 = 32'hB8; tick();
        chk("simul_full", {31'd0, full0}, 32'd1);
        rd_en0 = 1'b1;
        data_in0 = 32'hB9;
        tick();
        wr_en0 = 1'b0;
        chk("full_rw_dout", data_out0, 32'hB5);
        chk("full_rw_count", {29'd0, count0}, 32'd3);
        chk("full_rw_ovf", {31'd0, ovf0}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("full_rw_drain", data_out0, 32'hB6 + i);
        end
        rd_en0 = 1'b0;
        clear_err0 = 1'b1;
        tick();
        clear_err0 = 1'b0;
        chk("clr_ovf", {31'd0, ovf0}, 32'd0);
        chk("clr_unf2", {31'd0, unf0}, 32'd0);

        // flush
        wr_en0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in0 = 32'hC0 + i;
            tick();
        end
        chk("preflush_count", {29'd0, count0}, 32'd3);
        flush0 = 1'b1;
        rd_en0 = 1'b1;
        data_in0 = 32'hC3;
        tick();
        flush0 = 1'b0; wr_en0 = 1'b0; rd_en0 = 1'b0;
        chk("flush_count", {29'd0, count0}, 32'd0);
        chk("flush_empty", {31'd0, empty0}, 32'd1);
        chk("flush_ovf", {31'd0, ovf0}, 32'd0);
        chk("flush_unf", {31'd0, unf0}, 32'd0);
        chk("flush_dout", data_out0, 32'hB8);
        wr_en0 = 1'b1; data_in0 = 32'hD0; tick();
        wr_en0 = 1'b0; rd_en0 = 1'b1; tick();
        rd_en0 = 1'b0;
        chk("postflush_dout", data_out0, 32'hD0);

        // async reset mid-fill
        wr_en0 = 1'b1;
        data_in0 = 32'hE0; tick();
        data_in0 = 32'hE1; tick();
        wr_en0 = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_count", {29'd0, count0}, 32'd0);
        chk("midrst_empty", {31'd0, empty0}, 32'd1);
        chk("midrst_full", {31'd0, full0}, 32'd0);
        chk("midrst_ae", {31'd0, ae0}, 32'd1);
        chk("midrst_af", {31'd0, af0}, 32'd0);
        chk("midrst_dout", data_out0, 32'd0);
        tick();
        reset = 1'b0;
        wr_en0 = 1'b1; data_in0 = 32'hE2; tick();
        wr_en0 = 1'b0; rd_en0 = 1'b1; tick();
        rd_en0 = 1'b0;
        chk("postrst_dout", data_out0, 32'hE2);
        chk("postrst_count", {29'd0, count0}, 32'd0);

        // first-word-fall-through
        wr_en1 = 1'b1; data_in1 = 32'h11; tick();
        wr_en1 = 1'b0;
        chk("fwft_first", data_out1, 32'h11);
        chk("fwft_nonempty", {31'd0, empty1}, 32'd0);
        wr_en1 = 1'b1; data_in1 = 32'h22; tick();
        wr_en1 = 1'b0;
        chk("fwft_hold", data_out1, 32'h11);
        chk("fwft_count2", {29'd0, count1}, 32'd2);
        rd_en1 = 1'b1; tick();
        rd_en1 = 1'b0;
        chk("fwft_next", data_out1, 32'h22);
        chk("fwft_count1", {29'd0, count1}, 32'd1);
        rd_en1 = 1'b1; tick();
        chk("fwft_empty", {31'd0, empty1}, 32'd1);
        tick();
        rd_en1 = 1'b0;
        chk("fwft_unf", {31'd0, unf1}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
